// File: rtl/led_fader_pkg.sv
// Shared defaults, ramp direction type and duty mapping for led_fader.
// Defining LED_FADER_GAMMA_EN switches level_eff from linear to a squared curve.
package led_fader_pkg;

  localparam int unsigned LED_FADER_CHANNELS = 5;
  localparam int unsigned LED_FADER_PWM_BITS = 8;
  localparam int unsigned LED_FADER_STEP_DIV = 65536;

  typedef enum logic [1:0] {
    RAMP_HOLD = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } ramp_dir_e;

  function automatic int unsigned level_max(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

  function automatic int unsigned level_eff(input int unsigned level, input int unsigned bits);
`ifdef LED_FADER_GAMMA_EN
    // Full scale is pinned so a finished fade-in is truly constant on.
    if (level == level_max(bits)) begin
      return level;
    end
    return (level * level) >> bits;
`else
    return level & level_max(bits);
`endif
  endfunction

endpackage

// File: rtl/led_fader_if.sv
// Request/drive bundle between the LED pattern logic (master) and led_fader (slave).
interface led_fader_if
  import led_fader_pkg::*;
#(
  parameter int unsigned CHANNELS = LED_FADER_CHANNELS
);

  logic [CHANNELS-1:0] led_req;
  logic [CHANNELS-1:0] led_out;
  logic                pwm_sync;
  logic                busy;

  modport master (
    output led_req,
    input  led_out,
    input  pwm_sync,
    input  busy
  );

  modport slave (
    input  led_req,
    output led_out,
    output pwm_sync,
    output busy
  );

endinterface

// File: rtl/led_fader_channel.sv
// One LED channel: saturating brightness ramp, per-period duty latch and PWM compare.
// Duty mapping follows level_eff (linear, or gamma with LED_FADER_GAMMA_EN).
module led_fader_channel
  import led_fader_pkg::*;
#(
  parameter int unsigned PWM_BITS = LED_FADER_PWM_BITS
)
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_tick,
  input  logic                i_wrap,
  input  logic [PWM_BITS-1:0] i_pwm_cnt,
  input  logic                i_req,
  output logic                o_led,
  output logic                o_at_target
);

  localparam logic [PWM_BITS-1:0] MAX = PWM_BITS'(level_max(PWM_BITS));

  logic [PWM_BITS-1:0] r_level;
  logic [PWM_BITS-1:0] r_duty;
  logic                r_led;
  logic [PWM_BITS-1:0] w_level_next;
  logic [PWM_BITS-1:0] w_duty_next;
  ramp_dir_e           w_dir;

  always_comb begin
    w_dir = RAMP_HOLD;
    if (i_tick) begin
      if (i_req && (r_level != MAX)) begin
        w_dir = RAMP_UP;
      end else if (!i_req && (r_level != '0)) begin
        w_dir = RAMP_DOWN;
      end
    end
  end

  always_comb begin
    w_level_next = r_level;
    case (w_dir)
      RAMP_UP:   w_level_next = r_level + PWM_BITS'(1);
      RAMP_DOWN: w_level_next = r_level - PWM_BITS'(1);
      default:   w_level_next = r_level;
    endcase
  end

  assign w_duty_next = PWM_BITS'(level_eff(32'(r_level), PWM_BITS));

  // Duty captures the pre-update level on the wrap edge so a period never glitches.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_level <= '0;
      r_duty  <= '0;
      r_led   <= 1'b0;
    end else begin
      r_level <= w_level_next;
      if (i_wrap) begin
        r_duty <= w_duty_next;
      end
      r_led <= (r_duty == MAX) ? 1'b1 : (i_pwm_cnt < r_duty);
    end
  end

  assign o_led       = r_led;
  assign o_at_target = i_req ? (r_level == MAX) : (r_level == '0);

endmodule

// File: rtl/led_fader.sv
// LED PWM fader top: shared PWM counter, step prescaler, sync pulse and busy flag.
// Build option LED_FADER_GAMMA_EN selects gamma duty mapping in every channel.
module led_fader
  import led_fader_pkg::*;
#(
  parameter int unsigned CHANNELS = LED_FADER_CHANNELS,
  parameter int unsigned PWM_BITS = LED_FADER_PWM_BITS,
  parameter int unsigned STEP_DIV = LED_FADER_STEP_DIV
)
(
  input  logic       CLK_IN,
  input  logic       RST_IN,
  led_fader_if.slave bus
);

  localparam int unsigned         PS_BITS  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PS_BITS-1:0]  PS_LAST  = PS_BITS'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'(level_max(PWM_BITS));

  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [PS_BITS-1:0]  r_presc;
  logic                r_pwm_sync;
  logic                r_busy;
  logic                w_tick;
  logic                w_wrap;
  logic [CHANNELS-1:0] w_led;
  logic [CHANNELS-1:0] w_at_target;

  assign w_tick = (r_presc == PS_LAST);
  assign w_wrap = (r_pwm_cnt == PWM_LAST);

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      r_pwm_cnt  <= '0;
      r_presc    <= '0;
      r_pwm_sync <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_pwm_cnt  <= r_pwm_cnt + PWM_BITS'(1);
      r_presc    <= w_tick ? '0 : r_presc + PS_BITS'(1);
      r_pwm_sync <= (r_pwm_cnt == '0);
      r_busy     <= ~&w_at_target;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    led_fader_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_ch (
      .i_clk       (CLK_IN),
      .i_rst       (RST_IN),
      .i_tick      (w_tick),
      .i_wrap      (w_wrap),
      .i_pwm_cnt   (r_pwm_cnt),
      .i_req       (bus.led_req[g]),
      .o_led       (w_led[g]),
      .o_at_target (w_at_target[g])
    );
  end

  assign bus.led_out  = w_led;
  assign bus.pwm_sync = r_pwm_sync;
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_led_fader.sv
// Directed bench for led_fader at PWM_BITS=4, STEP_DIV=2; expected duties follow
// the gamma curve when LED_FADER_GAMMA_EN is defined.
module tb_led_fader;

  localparam int unsigned NCH = 5;
  localparam int unsigned PB  = 4;
  localparam int unsigned SD  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   ecount   = 0;
  int   ones     = 0;
  int   seq [8]  = '{1, 2, 3, 4, 3, 2, 1, 0};

  led_fader_if #(.CHANNELS(NCH)) bus ();

  led_fader #(
    .CHANNELS (NCH),
    .PWM_BITS (PB),
    .STEP_DIV (SD)
  ) dut (
    .CLK_IN (clk),
    .RST_IN (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic int exp_duty(input int l);
`ifdef LED_FADER_GAMMA_EN
    if (l == 15) return 15;
    return (l * l) / 16;
`else
    return l;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, exp, ecount);
    end
  endtask

  task automatic step();
    @(negedge clk);
    ecount++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst    = 1'b0;
    ecount = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and pwm_sync cadence
    bus.led_req = 5'b11111;
    apply_reset();
    check("rst_led_out", 32'(bus.led_out), 32'd0);
    check("rst_pwm_sync", 32'(bus.pwm_sync), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    release_reset();
    step();
    check("sync_first", 32'(bus.pwm_sync), 32'd1);
    check("busy_all_req", 32'(bus.busy), 32'd1);
    for (int e = 2; e <= 33; e++) begin
      step();
      check("sync_period", 32'(bus.pwm_sync), 32'(ecount % 16 == 1));
    end

    // Full ramp on channel 0
    apply_reset();
    bus.led_req = 5'b00001;
    release_reset();
    ones = 0;
    for (int e = 1; e <= 16; e++) begin
      step();
      if (bus.led_out[0]) ones++;
      check("ramp_others_off", 32'(bus.led_out[4:1]), 32'd0);
    end
    check("ramp_period1_ones", 32'(ones), 32'(exp_duty(0)));
    ones = 0;
    for (int e = 17; e <= 32; e++) begin
      step();
      if (bus.led_out[0]) ones++;
      if (ecount == 30) check("ramp_busy_before_top", 32'(bus.busy), 32'd1);
      if (ecount == 31) check("ramp_busy_drop", 32'(bus.busy), 32'd0);
    end
    check("ramp_period2_ones", 32'(ones), 32'(exp_duty(7)));
    check("ramp_level_max", 32'(dut.g_ch[0].u_ch.r_level), 32'd15);
    for (int e = 33; e <= 48; e++) begin
      step();
      check("ramp_full_on", 32'(bus.led_out), 32'b00001);
    end

    // Duty shape with level 6 latched at the wrap
    apply_reset();
    bus.led_req = '0;
    release_reset();
    steps(2);
    check("busy_idle", 32'(bus.busy), 32'd0);
    bus.led_req = 5'b00001;
    step();
    check("busy_req_edge", 32'(bus.busy), 32'd1);
    steps(13);
    for (int e = 17; e <= 32; e++) begin
      step();
      if (ecount == 17) check("duty6_sync", 32'(bus.pwm_sync), 32'd1);
      check("duty6_shape", 32'(bus.led_out[0]), 32'((ecount - 17) < exp_duty(6)));
    end

    // Level 8 latched at the wrap: linear 8 cycles, gamma 4 cycles
    apply_reset();
    bus.led_req = '0;
    release_reset();
    steps(14);
    bus.led_req = 5'b00001;
    steps(17);
    check("lvl8_level", 32'(dut.g_ch[0].u_ch.r_level), 32'd8);
    step();
    ones = 0;
    for (int e = 33; e <= 48; e++) begin
      step();
      if (bus.led_out[0]) ones++;
    end
    check("lvl8_ones", 32'(ones), 32'(exp_duty(8)));

    // Reversal mid-ramp
    apply_reset();
    bus.led_req = '0;
    release_reset();
    steps(2);
    bus.led_req = 5'b00001;
    for (int k = 0; k < 8; k++) begin
      steps(2);
      check("rev_level", 32'(dut.g_ch[0].u_ch.r_level), 32'(seq[k]));
      check("rev_busy", 32'(bus.busy), 32'd1);
      if (k == 3) bus.led_req = '0;
    end
    step();
    check("rev_busy_done", 32'(bus.busy), 32'd0);

    // Asynchronous reset at level 9
    apply_reset();
    bus.led_req = 5'b00001;
    release_reset();
    steps(18);
    check("arst_pre_level", 32'(dut.g_ch[0].u_ch.r_level), 32'd9);
    check("arst_pre_led", 32'(bus.led_out), 32'b00001);
    #2;
    rst = 1'b1;
    #1;
    check("arst_led_out", 32'(bus.led_out), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_level", 32'(dut.g_ch[0].u_ch.r_level), 32'd0);
    repeat (2) @(negedge clk);
    release_reset();
    step();
    check("arst_restart_busy", 32'(bus.busy), 32'd1);
    step();
    check("arst_restart_level", 32'(dut.g_ch[0].u_ch.r_level), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
